// File: rtl/hex_to_7seg.sv
// Registered hex-nibble to seven-segment decoder for one HEX display digit.
// Segment order {g,f,e,d,c,b,a}; ACTIVE_LOW selects low-true or high-true drive.
module hex_to_7seg #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex_input,
  output logic [6:0] seven_seg_out
);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0] lit_n;
  logic [6:0] seg_d;

  // Patterns are kept in low-true form (0 = lit); high-true boards get the complement.
  always_comb begin
    lit_n = 7'h7F;
    case (hex_input)
      4'h0: lit_n = 7'h40;
      4'h1: lit_n = 7'h79;
      4'h2: lit_n = 7'h24;
      4'h3: lit_n = 7'h30;
      4'h4: lit_n = 7'h19;
      4'h5: lit_n = 7'h12;
      4'h6: lit_n = 7'h02;
      4'h7: lit_n = 7'h78;
      4'h8: lit_n = 7'h00;
      4'h9: lit_n = 7'h10;
      4'hA: lit_n = 7'h08;
      4'hB: lit_n = 7'h03;
      4'hC: lit_n = 7'h46;
      4'hD: lit_n = 7'h21;
      4'hE: lit_n = 7'h06;
      4'hF: lit_n = 7'h0E;
      default: lit_n = 7'h7F;
    endcase
  end

  assign seg_d = (ACTIVE_LOW != 0) ? lit_n : ~lit_n;

  // Single output register: all segments switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seven_seg_out <= SEG_OFF;
    else     seven_seg_out <= seg_d;
  end

endmodule

// File: tb/tb_hex_to_7seg.sv
// Scoreboard bench for hex_to_7seg: low-true and high-true instances in parallel.
module tb_hex_to_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hex_input = 4'h8;
  logic [6:0] seg_lo, seg_hi;

  int checks = 0;
  int errors = 0;

  logic [6:0] ref_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] exp_lo_q [$];
  logic [6:0] exp_hi_q [$];

  always #5 clk = ~clk;

  hex_to_7seg #(.ACTIVE_LOW(1)) u_lo (
    .clk(clk), .rst(rst), .hex_input(hex_input), .seven_seg_out(seg_lo)
  );

  hex_to_7seg #(.ACTIVE_LOW(0)) u_hi (
    .clk(clk), .rst(rst), .hex_input(hex_input), .seven_seg_out(seg_hi)
  );

  task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 7'h%02h, expected 7'h%02h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive a nibble away from the active edge, push expectations, compare after the edge.
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge clk);
    hex_input = v;
    exp_lo_q.push_back(ref_lut[v]);
    exp_hi_q.push_back(~ref_lut[v]);
    @(posedge clk);
    #1;
    chk({tag, "_lo"}, seg_lo, exp_lo_q.pop_front());
    chk({tag, "_hi"}, seg_hi, exp_hi_q.pop_front());
  endtask

  initial begin
    // Reset held with clock running and input changing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hex_input = (i == 1) ? 4'h3 : 4'h8;
      #1;
      chk("rst_hold_lo", seg_lo, 7'h7F);
      chk("rst_hold_hi", seg_hi, 7'h00);
    end
    @(negedge clk);
    hex_input = 4'h8;
    rst = 1'b0;
    #1;
    chk("rst_rel_lo", seg_lo, 7'h7F);
    @(posedge clk);
    #1;
    chk("first_edge_lo", seg_lo, 7'h00);
    chk("first_edge_hi", seg_hi, 7'h7F);

    // Full sweep, each value held for two edges
    for (int v = 0; v < 16; v++) begin
      step(4'(v), "sweep");
      step(4'(v), "hold");
    end

    // Latency: input change between edges must not reach the output early
    step(4'h1, "lat1");
    @(negedge clk);
    hex_input = 4'h2;
    #1;
    chk("lat_early_lo", seg_lo, 7'h79);
    chk("lat_early_hi", seg_hi, 7'h06);
    @(posedge clk);
    #1;
    chk("lat_edge_lo", seg_lo, 7'h24);

    // Async reset mid-stream, no clock edge in between
    step(4'h9, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_lo", seg_lo, 7'h7F);
    chk("async_rst_hi", seg_hi, 7'h00);
    @(posedge clk);
    #1;
    chk("async_hold_lo", seg_lo, 7'h7F);
    @(negedge clk);
    hex_input = 4'hC;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_lo", seg_lo, 7'h46);
    chk("post_rst_hi", seg_hi, 7'h39);

    // Wrap F -> 0 on consecutive cycles
    step(4'hF, "wrapF");
    step(4'h0, "wrap0");

    // A few random nibbles through the scoreboard
    for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), "rand");

    checks++;
    if (exp_lo_q.size() != 0 || exp_hi_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d/%0d entries left, expected 0", exp_lo_q.size(), exp_hi_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
